// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the vectored interrupt controller: register offsets,
// FSM encoding and the source-ID width.
package irq_ctrl_pkg;

    localparam int ID_W = 3;

    localparam logic [1:0] OFF_PENDING = 2'd0;
    localparam logic [1:0] OFF_MASK    = 2'd1;
    localparam logic [1:0] OFF_CAUSE   = 2'd2;
    localparam logic [1:0] OFF_EOI     = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: source 0 wins over every other source.
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = 3
) (
    input  logic [N_SRC-1:0] req,
    output logic             valid,
    output logic [ID_W-1:0]  id
);

    always_comb begin
        valid = |req;
        id    = '0;
        // Walk downwards so the lowest set index is the last one written.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) id = ID_W'(i);
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Vectored interrupt controller: rising-edge latching, software mask, single
// request to the pipeline and EOI handshake over the MEM-stage bus.
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter int          N_SRC     = 3,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0030
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_irq,
    input  logic             mem_rd,
    input  logic             mem_wr,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic             kernel_mode,
    input  logic             irq_taken,
    output logic             irq_out
);

    irq_state_t       r_state, w_state_nxt;
    logic [N_SRC-1:0] r_src_d, r_pending, r_mask;
    logic [ID_W-1:0]  r_cause_id;
    logic             r_in_service;

    logic             w_sel, w_eoi, w_eoi_ok, w_mask_wr, w_take, w_valid;
    logic [1:0]       w_off;
    logic [ID_W-1:0]  w_eoi_id, w_win_id;
    logic [N_SRC-1:0] w_rise, w_clr;
    logic             w_unused;

    assign w_sel     = (addr[31:4] == BASE_ADDR[31:4]);
    assign w_off     = addr[3:2];
    assign w_rise    = src_irq & ~r_src_d;
    assign w_mask_wr = mem_wr && w_sel && (w_off == OFF_MASK);
    assign w_eoi     = mem_wr && w_sel && (w_off == OFF_EOI);
    assign w_eoi_id  = wdata[ID_W-1:0];
    // IDs beyond the implemented sources are dropped entirely, FSM included.
    assign w_eoi_ok  = w_eoi && ({29'b0, w_eoi_id} < 32'(N_SRC));
    assign w_take    = (r_state == REQ) && irq_taken;
    assign w_unused  = ^{addr[1:0], wdata[31:ID_W]};

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_clr[i] = w_eoi_ok && (w_eoi_id == ID_W'(i));
        end
    end

    irq_prio_enc #(.N_SRC(N_SRC)) u_prio (
        .req   (r_pending & r_mask),
        .valid (w_valid),
        .id    (w_win_id)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_src_d      <= '0;
            r_pending    <= '0;
            r_mask       <= '0;
            r_cause_id   <= '0;
            r_in_service <= 1'b0;
        end else begin
            r_src_d <= src_irq;
            // A new edge outranks a same-cycle EOI clear of that bit.
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (w_mask_wr) r_mask <= wdata[N_SRC-1:0];
            if (w_take) begin
                r_cause_id   <= w_win_id;
                r_in_service <= 1'b1;
            end else if ((r_state == SERVICE) && w_eoi_ok) begin
                r_in_service <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_valid) w_state_nxt = REQ;
            // A take in the same cycle the request collapses still enters
            // service, since the pipeline has already vectored.
            REQ:     if (irq_taken) w_state_nxt = SERVICE;
                     else if (!w_valid) w_state_nxt = IDLE;
            SERVICE: if (w_eoi_ok) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign irq_out = (r_state == REQ) && !kernel_mode;

    always_comb begin
        rdata = 32'h0;
        if (mem_rd && w_sel) begin
            case (w_off)
                OFF_PENDING: rdata = 32'(r_pending);
                OFF_MASK:    rdata = 32'(r_mask);
                OFF_CAUSE:   rdata = {r_in_service, 28'b0, r_cause_id};
                default:     rdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: reset, latching, priority, EOI, kernel
// hold-off, bus decode and reset during service.
module tb_irq_controller;

    localparam logic [31:0] BASE   = 32'h4000_0030;
    localparam logic [31:0] A_PEND = BASE + 32'h0;
    localparam logic [31:0] A_MASK = BASE + 32'h4;
    localparam logic [31:0] A_CAUS = BASE + 32'h8;
    localparam logic [31:0] A_EOI  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  src_irq = '0;
    logic        mem_rd = 1'b0, mem_wr = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        kernel_mode = 1'b0, irq_taken = 1'b0;
    logic        irq_out;

    int n_vec = 0;
    int n_err = 0;

    irq_controller #(.N_SRC(3), .BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .reset       (reset),
        .src_irq     (src_irq),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .kernel_mode (kernel_mode),
        .irq_taken   (irq_taken),
        .irq_out     (irq_out)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        mem_rd = 1'b1;
        addr   = a;
        #1;
        chk(tag, rdata, exp);
        mem_rd = 1'b0;
        addr   = '0;
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mem_wr = 1'b1;
        addr   = a;
        wdata  = d;
        cyc();
        mem_wr = 1'b0;
        addr   = '0;
        wdata  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        cyc(); cyc();
        chk("rst_irq_out", 32'(irq_out), 32'h0);
        rd_chk("rst_pending", A_PEND, 32'h0);
        rd_chk("rst_cause", A_CAUS, 32'h0);
        reset = 1'b1;
        cyc();

        // Masked source latches but never requests
        src_irq = 3'b010;
        cyc();
        src_irq = 3'b000;
        cyc();
        rd_chk("masked_pending", A_PEND, 32'h2);
        chk("masked_no_irq", 32'(irq_out), 32'h0);
        wr(A_EOI, 32'd1);
        rd_chk("eoi_idle_clears", A_PEND, 32'h0);

        // Enable all, raise src 2 and src 0 together
        wr(A_MASK, 32'h7);
        rd_chk("mask_rb", A_MASK, 32'h7);
        src_irq = 3'b101;
        #1 chk("lat_t0", 32'(irq_out), 32'h0);
        cyc();
        chk("lat_t1", 32'(irq_out), 32'h0);
        rd_chk("pend_101", A_PEND, 32'h5);
        cyc();
        chk("lat_t2_req", 32'(irq_out), 32'h1);

        irq_taken = 1'b1;
        cyc();
        irq_taken = 1'b0;
        chk("taken_drop", 32'(irq_out), 32'h0);
        rd_chk("cause_src0", A_CAUS, 32'h8000_0000);

        // EOI 0: one IDLE cycle then REQ for src 2
        wr(A_EOI, 32'd0);
        chk("eoi_idle_cycle", 32'(irq_out), 32'h0);
        rd_chk("cause_after_eoi", A_CAUS, 32'h0);
        cyc();
        chk("eoi_rereq", 32'(irq_out), 32'h1);

        // Kernel mode hold-off
        kernel_mode = 1'b1;
        #1 chk("kernel_block", 32'(irq_out), 32'h0);
        cyc(); cyc();
        chk("kernel_hold", 32'(irq_out), 32'h0);
        kernel_mode = 1'b0;
        #1 chk("kernel_release", 32'(irq_out), 32'h1);

        irq_taken = 1'b1;
        cyc();
        irq_taken = 1'b0;
        rd_chk("cause_src2", A_CAUS, 32'h8000_0002);

        // Rising edge on src 1 with same-cycle EOI of 1: set wins
        src_irq = 3'b111;
        wr(A_EOI, 32'd1);
        rd_chk("set_beats_clr", A_PEND, 32'h6);
        rd_chk("cause_retained", A_CAUS, 32'h0000_0002);
        cyc();
        chk("req_src1", 32'(irq_out), 32'h1);

        // Bus decode
        rd_chk("unmapped_rd", 32'h4000_0000, 32'h0);
        rd_chk("eoi_reads_0", A_EOI, 32'h0);
        addr = A_PEND;
        #1 chk("no_rd_strobe", rdata, 32'h0);
        addr = '0;
        wr(A_EOI, 32'd7);
        rd_chk("eoi7_pend", A_PEND, 32'h6);
        chk("eoi7_state", 32'(irq_out), 32'h1);

        // Build pending=101 then enter service
        src_irq = 3'b000;
        wr(A_EOI, 32'd1);
        src_irq = 3'b001;
        cyc();
        src_irq = 3'b000;
        rd_chk("pend_101_b", A_PEND, 32'h5);
        irq_taken = 1'b1;
        cyc();
        irq_taken = 1'b0;
        rd_chk("svc_cause", A_CAUS, 32'h8000_0000);

        // Reset mid-service
        reset = 1'b0;
        #1;
        chk("rst2_irq_out", 32'(irq_out), 32'h0);
        rd_chk("rst2_pending", A_PEND, 32'h0);
        rd_chk("rst2_mask", A_MASK, 32'h0);
        rd_chk("rst2_cause", A_CAUS, 32'h0);
        cyc();
        reset = 1'b1;
        cyc();
        chk("rst2_idle", 32'(irq_out), 32'h0);

        // Nominal latency after reset
        wr(A_MASK, 32'h1);
        src_irq = 3'b001;
        #1 chk("post_t0", 32'(irq_out), 32'h0);
        cyc();
        chk("post_t1", 32'(irq_out), 32'h0);
        cyc();
        chk("post_t2", 32'(irq_out), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
# irq_controller

Vectored interrupt controller between the MEM-stage peripherals (UART rx/tx, timer/peripheral) and the pipeline's IRQ input. It latches rising edges from up to eight sources into a pending register and applies a software mask. It raises a single request to the control unit and captures the winning source ID when the pipeline takes the interrupt. It holds off further requests until the handler writes end-of-interrupt (EOI) through the memory-mapped bus shared with DataMem/Peripheral/Uart.

## Interface
- N_SRC, 3: number of interrupt sources, 1..8; source 0 has highest priority.
- BASE_ADDR, 32'h4000_0030: base address of the 16-byte register window; must be 16-byte aligned.
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low.
- src_irq  in  N_SRC  level interrupt lines, synchronous to clk.
- mem_rd  in  1  MEM-stage read strobe.
- mem_wr  in  1  MEM-stage write strobe.
- addr  in  32  MEM-stage byte address (ALU result).
- wdata  in  32  MEM-stage store data.
- rdata  out  32  read data; must be 32'h0 when not selected, because it is OR-merged with the other MEM-stage read data.
- kernel_mode  in  1  PC[31] of the instruction in ID; 1 blocks new requests.
- irq_taken  in  1  one-cycle pulse from the pipeline: the interrupt vector was selected this cycle.
- irq_out  out  1  interrupt request to the control unit.

## Operation
- Edge detect: src_d <= src_irq each cycle; rise = src_irq & ~src_d. A rising edge sets pending[i].
- The window is selected when addr[31:4] == BASE_ADDR[31:4]. Register offset is addr[3:2]:
  - 0 PENDING: read-only, {0, pending}.
  - 1 MASK: read/write, low N_SRC bits; 1 = enabled.
  - 2 CAUSE: read-only, {in_service, 28'b0, cause_id[2:0]}.
  - 3 EOI: write-only; wdata[2:0] = source ID; reads as 0.
- Reads are combinational: rdata is valid in the same cycle as mem_rd && selected, otherwise 32'h0. Writes take effect at the clock edge.
- Priority: winner = lowest index with pending & mask set. valid = |(pending & mask).
- State machine:
  - IDLE → REQ when valid.
  - REQ → IDLE when valid drops (source masked or cleared) before irq_taken.
  - REQ → SERVICE on irq_taken. On this transition cause_id <= winner and in_service <= 1.
  - SERVICE → IDLE on an EOI write. The EOI write clears pending[wdata[2:0]]; in_service <= 0; cause_id is retained.
- irq_out = (state == REQ) && !kernel_mode. REQ persists while kernel_mode=1.
- EOI outside SERVICE only clears the addressed pending bit; the state is unchanged.
- EOI with ID ≥ N_SRC is ignored in full: no pending bit changes and the state is unchanged.
- Same-cycle rising edge and EOI clear on the same bit: the set wins (pending stays 1).
- irq_taken outside REQ is ignored.
- The MASK write and the winner evaluation in the same cycle use the old MASK.
- MASK does not affect pending latching; masked sources accumulate.

## Timing
- Reset values: every output and register is 0 (irq_out=0, rdata=0, pending=0, MASK=0, cause_id=0, in_service=0, src_d=0), state = IDLE. Reset mid-SERVICE abandons the service silently.
- Source rising edge at cycle t: pending set at edge t+1; REQ entered at edge t+2; irq_out high in cycle t+2, provided the source is unmasked and kernel_mode=0.
- irq_out drops in the cycle after irq_taken.
- After EOI at edge e, a still-pending unmasked source reaches REQ at edge e+1 (one IDLE cycle).
- Register reads have zero latency; all state is registered and there are no combinational paths from wdata to irq_out.

## Structure
- Package irq_ctrl_pkg holds:
  - register offsets OFF_PENDING=0, OFF_MASK=1, OFF_CAUSE=2, OFF_EOI=3;
  - state encoding IDLE=2'd0, REQ=2'd1, SERVICE=2'd2;
  - ID_W=3.
- Sub-module irq_prio_enc is a combinational lowest-index-first encoder with ports req[N_SRC-1:0], valid and id[2:0].
- The top module holds the edge detect, the registers, the FSM and the bus decode.

## Test plan
- Reset release, MASK=0, pulse src_irq[1]: PENDING reads 32'h2 and irq_out stays 0.
- Write MASK=3'b111, assert src 2 then src 0 in the same cycle: irq_out rises. irq_taken gives CAUSE=32'h8000_0000. An EOI write of 0 gives IDLE, then REQ one cycle later; the second irq_taken gives CAUSE low bits 2.
- kernel_mode=1 while in REQ: irq_out=0 and the state holds. kernel_mode→0: irq_out=1 the same cycle.
- Rising edge of src 1 in the same cycle as an EOI write of 1: PENDING bit 1 remains 1.
- Reads at unmapped addresses (e.g. 32'h4000_0000) and with mem_rd=0 return 0. EOI writing 7 with N_SRC=3 changes nothing.
- Assert reset during SERVICE with pending=3'b101: all registers and outputs are 0 and the state is IDLE. The first rising edge after reset behaves per the nominal latency.
